zcheck_sweep_ctrl: RTL and testbench

//  Sequences impedance checks for rhd_2048 across a range of global channels.
//  For each channel it pulses zcheck_start, waits for completion and captures the magnitude.
//  If the result saturates, it steps the scale down and retries.

---
 rtl/zcheck_sweep_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_zcheck_sweep_ctrl.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zcheck_sweep_ctrl.sv
// Impedance-check sweep sequencer for rhd_2048: walks a channel range,
// retries saturated readings at lower scale and streams results out.
module zcheck_sweep_ctrl #(
    parameter int               NUM_CHANNELS   = 2048,
    parameter int               CH_W           = 12,
    parameter int               MAG_W          = 16,
    parameter int               SETTLE_CYCLES  = 1000,
    parameter int               TIMEOUT_CYCLES = 2000000,
    parameter logic [MAG_W-1:0] SAT_THRESH     = 16'hF000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sweep_start,
    input  logic             sweep_abort,
    input  logic [CH_W-1:0]  first_channel,
    input  logic [CH_W-1:0]  last_channel,
    input  logic [1:0]       start_scale,
    output logic             zcheck_start,
    output logic [CH_W-1:0]  zcheck_global_channel,
    output logic [1:0]       zcheck_scale,
    input  logic             zcheck_busy,
    input  logic             zcheck_done,
    input  logic [MAG_W-1:0] zcheck_mag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CH_W-1:0]  res_channel,
    output logic [1:0]       res_scale,
    output logic [MAG_W-1:0] res_mag,
    output logic             res_sat,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             sweep_err
);

    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ?
                             SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_W:0]    NUM_CH      = (CH_W + 1)'(NUM_CHANNELS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_IDLE,
        S_START,
        S_WAIT_DONE,
        S_EVAL,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]  last_q, last_d;
    logic [1:0]       sscale_q, sscale_d;
    logic [1:0]       scale_q, scale_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             rvalid_q, rvalid_d;
    logic [CH_W-1:0]  rch_q, rch_d;
    logic [1:0]       rscale_q, rscale_d;
    logic [MAG_W-1:0] rmag_q, rmag_d;
    logic             rsat_q, rsat_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             sat;
    logic             bad_range;

    assign sat       = (mag_q >= SAT_THRESH);
    assign bad_range = (first_channel > last_channel) ||
                       ({1'b0, last_channel} >= NUM_CH);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        last_d   = last_q;
        sscale_d = sscale_q;
        scale_d  = scale_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        rvalid_d = rvalid_q;
        rch_d    = rch_q;
        rscale_d = rscale_q;
        rmag_d   = rmag_q;
        rsat_d   = rsat_q;
        err_d    = err_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (sweep_start) begin
                    if (bad_range) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        ch_d     = first_channel;
                        last_d   = last_channel;
                        sscale_d = start_scale;
                        scale_d  = start_scale;
                        cnt_d    = '0;
                        state_d  = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (sweep_abort) begin
                    state_d = S_FINISH;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (sweep_abort) begin
                    state_d = S_FINISH;
                end else if (!zcheck_busy) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            // A measurement in flight is never abandoned, even on abort
            S_WAIT_DONE: begin
                if (zcheck_done) begin
                    mag_d   = zcheck_mag;
                    state_d = S_EVAL;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (sat && (scale_q != 2'd0)) begin
                    scale_d = scale_q - 2'd1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end else begin
                    rvalid_d = 1'b1;
                    rch_d    = ch_q;
                    rscale_d = scale_q;
                    rmag_d   = mag_q;
                    rsat_d   = sat;
                    state_d  = S_EMIT;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    rvalid_d = 1'b0;
                    if (sweep_abort || (ch_q == last_q)) begin
                        state_d = S_FINISH;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        scale_d = sscale_q;
                        cnt_d   = '0;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            last_q   <= '0;
            sscale_q <= '0;
            scale_q  <= '0;
            cnt_q    <= '0;
            mag_q    <= '0;
            rvalid_q <= 1'b0;
            rch_q    <= '0;
            rscale_q <= '0;
            rmag_q   <= '0;
            rsat_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
            sscale_q <= sscale_d;
            scale_q  <= scale_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            rvalid_q <= rvalid_d;
            rch_q    <= rch_d;
            rscale_q <= rscale_d;
            rmag_q   <= rmag_d;
            rsat_q   <= rsat_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign zcheck_start          = (state_q == S_START);
    assign zcheck_global_channel = ch_q;
    assign zcheck_scale          = scale_q;
    assign res_valid             = rvalid_q;
    assign res_channel           = rch_q;
    assign res_scale             = rscale_q;
    assign res_mag               = rmag_q;
    assign res_sat               = rsat_q;
    assign sweep_busy            = (state_q != S_IDLE);
    assign sweep_done            = done_q;
    assign sweep_err             = err_q;

endmodule

// File: tb/tb_zcheck_sweep_ctrl.sv
// Bench for zcheck_sweep_ctrl: vector table, directed corner sequences
// and randomized sweeps checked against a sweep-level reference model.
module tb_zcheck_sweep_ctrl;

    localparam int          SETTLE = 8;
    localparam int          TMO    = 300;
    localparam logic [15:0] THR    = 16'hF000;

    typedef struct packed {
        logic [11:0] ch;
        logic [1:0]  sc;
        logic [15:0] mag;
        logic        sat;
    } res_t;

    typedef struct {
        int first;
        int last;
        int ss;
        int mmode;
        int cmag;
        int rmode;
        int exp_err;
        int exp_nres;
        int exp_nreq;
    } vec_t;

    logic        clk, rst;
    logic        sweep_start, sweep_abort;
    logic [11:0] first_channel, last_channel;
    logic [1:0]  start_scale;
    logic        zcheck_start;
    logic [11:0] zcheck_global_channel;
    logic [1:0]  zcheck_scale;
    logic        zcheck_busy, zcheck_done;
    logic [15:0] zcheck_mag;
    logic        res_valid, res_ready;
    logic [11:0] res_channel;
    logic [1:0]  res_scale;
    logic [15:0] res_mag;
    logic        res_sat;
    logic        sweep_busy, sweep_done, sweep_err;

    zcheck_sweep_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sweep_start          (sweep_start),
        .sweep_abort          (sweep_abort),
        .first_channel        (first_channel),
        .last_channel         (last_channel),
        .start_scale          (start_scale),
        .zcheck_start         (zcheck_start),
        .zcheck_global_channel(zcheck_global_channel),
        .zcheck_scale         (zcheck_scale),
        .zcheck_busy          (zcheck_busy),
        .zcheck_done          (zcheck_done),
        .zcheck_mag           (zcheck_mag),
        .res_valid            (res_valid),
        .res_ready            (res_ready),
        .res_channel          (res_channel),
        .res_scale            (res_scale),
        .res_mag              (res_mag),
        .res_sat              (res_sat),
        .sweep_busy           (sweep_busy),
        .sweep_done           (sweep_done),
        .sweep_err            (sweep_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          stab_bad = 0;
    res_t        got_res[$];
    res_t        exp_res[$];
    logic [13:0] req_q[$];
    logic [13:0] exp_req[$];

    int          mag_mode = 0;
    logic [15:0] cmag = 16'h0;
    logic [15:0] scale_tab[4];
    logic [31:0] seed = 32'h0;
    int          rmode = 0;
    int          lat = 5;
    bit          lat_rand = 0;
    bit          eng_en = 1;
    bit          spur_en = 0;
    bit          force_busy = 0;
    bit          eng_act = 0;
    int          eng_cnt = 0;
    logic [15:0] eng_m = 16'h0;
    int          vcnt = 0;

    assign zcheck_busy = force_busy || eng_act;

    function automatic logic [15:0] eng_mag(input int ch, input int sc);
        logic [31:0] h;
        case (mag_mode)
            0: return cmag;
            1: return scale_tab[sc];
            default: begin
                h = (32'(ch) * 32'd2654435761) ^ (32'(sc) * 32'd40503) ^ seed;
                h = h ^ (h >> 13);
                if (h[20:19] == 2'b00) return {4'hF, h[11:0]};
                return {4'h0, h[11:0]};
            end
        endcase
    endfunction

    // Sweep-level model: per channel, retry at lower scale while saturated
    task automatic build_model(input int f, input int l, input int ss);
        int          s;
        logic [15:0] m;
        res_t        r;
        exp_res.delete();
        exp_req.delete();
        for (int ch = f; ch <= l; ch++) begin
            s = ss;
            forever begin
                m = eng_mag(ch, s);
                exp_req.push_back({12'(ch), 2'(s)});
                if (m >= THR && s > 0) begin
                    s = s - 1;
                end else begin
                    r.ch  = 12'(ch);
                    r.sc  = 2'(s);
                    r.mag = m;
                    r.sat = (m >= THR);
                    exp_res.push_back(r);
                    break;
                end
            end
        end
    endtask

    // rhd_2048 engine stand-in and result consumer
    always @(posedge clk) begin
        #1;
        if (rst) begin
            eng_act     = 0;
            eng_cnt     = 0;
            zcheck_done = 1'b0;
            zcheck_mag  = 16'h0;
            vcnt        = 0;
            res_ready   = 1'b0;
        end else begin
            zcheck_done = 1'b0;
            zcheck_mag  = 16'($urandom);
            if (eng_act) begin
                if (eng_cnt <= 1) begin
                    zcheck_done = 1'b1;
                    zcheck_mag  = eng_m;
                    eng_act     = 0;
                end else begin
                    eng_cnt--;
                end
            end else if (spur_en && !zcheck_start &&
                         $urandom_range(0, 9) == 0) begin
                zcheck_done = 1'b1;
            end
            if (zcheck_start) begin
                req_q.push_back({zcheck_global_channel, zcheck_scale});
                if (eng_en) begin
                    eng_act = 1;
                    eng_cnt = lat_rand ? int'($urandom_range(1, 12)) : lat;
                    eng_m   = eng_mag(int'(zcheck_global_channel),
                                      int'(zcheck_scale));
                end
            end
            if (res_valid) vcnt++;
            else vcnt = 0;
            case (rmode)
                0: res_ready = 1'b1;
                1: res_ready = (vcnt > 20);
                default: res_ready = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    logic        pv = 0, phs = 0;
    logic [30:0] prd = '0;

    always @(negedge clk) begin
        res_t r;
        cyc++;
        if (rst) begin
            pv  = 0;
            phs = 0;
        end else begin
            if (pv && !phs) begin
                if (!res_valid ||
                    {res_channel, res_scale, res_mag, res_sat} != prd)
                    stab_bad++;
            end
            phs = res_valid && res_ready;
            if (phs) begin
                r.ch  = res_channel;
                r.sc  = res_scale;
                r.mag = res_mag;
                r.sat = res_sat;
                got_res.push_back(r);
            end
            pv  = res_valid;
            prd = {res_channel, res_scale, res_mag, res_sat};
            if (sweep_done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input string nm,
                       input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %0h expected %0h", tag, nm, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({zcheck_start, zcheck_global_channel, zcheck_scale,
                    res_valid, res_channel, res_scale, res_mag, res_sat,
                    sweep_busy, sweep_done, sweep_err});
    endfunction

    task automatic do_sweep(input int f, input int l, input int ss,
                            output int d0);
        @(posedge clk);
        #1;
        got_res.delete();
        req_q.delete();
        stab_bad      = 0;
        d0            = done_cnt;
        first_channel = 12'(f);
        last_channel  = 12'(l);
        start_scale   = 2'(ss);
        sweep_start   = 1'b1;
        @(posedge clk);
        #1;
        sweep_start   = 1'b0;
        first_channel = 12'($urandom);
        last_channel  = 12'($urandom);
        start_scale   = 2'($urandom);
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) break;
        end
        if (done_cnt == d0) begin
            chk(tag, "done_wait", 64'(0), 64'(1));
        end else begin
            chk(tag, "busy_at_done", 64'(sweep_busy), 64'(0));
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic check_sweep(input string tag, input int exp_err,
                               input int d0);
        int n;
        chk(tag, "n_res", 64'(got_res.size()), 64'(exp_res.size()));
        n = (got_res.size() < exp_res.size()) ? got_res.size() : exp_res.size();
        for (int i = 0; i < n; i++)
            chk(tag, "res", 64'(got_res[i]), 64'(exp_res[i]));
        chk(tag, "n_req", 64'(req_q.size()), 64'(exp_req.size()));
        n = (req_q.size() < exp_req.size()) ? req_q.size() : exp_req.size();
        for (int i = 0; i < n; i++)
            chk(tag, "req", 64'(req_q[i]), 64'(exp_req[i]));
        chk(tag, "err", 64'(sweep_err), 64'(exp_err));
        chk(tag, "done_pulses", 64'(done_cnt - d0), 64'(1));
        chk(tag, "stable", 64'(stab_bad), 64'(0));
        chk(tag, "busy_after", 64'(sweep_busy), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    vec_t vt[$];

    initial begin
        int d0, t0, f, l;
        vec_t v;
        rst           = 1'b1;
        sweep_start   = 1'b0;
        sweep_abort   = 1'b0;
        first_channel = 12'h0;
        last_channel  = 12'h0;
        start_scale   = 2'd0;
        res_ready     = 1'b0;
        zcheck_done   = 1'b0;
        zcheck_mag    = 16'h0;
        scale_tab[0]  = 16'h0010;
        scale_tab[1]  = 16'h0800;
        scale_tab[2]  = 16'hF100;
        scale_tab[3]  = 16'hF800;

        //      first last ss mm cmag     rm err nres nreq
        vt.push_back('{29,   29,   3, 0, 'h1234, 0, 0, 1, 1});
        vt.push_back('{0,    3,    0, 0, 'h0100, 1, 0, 4, 4});
        vt.push_back('{5,    5,    3, 1, 'h0,    0, 0, 1, 3});
        vt.push_back('{7,    7,    3, 0, 'hFFFF, 0, 0, 1, 4});
        vt.push_back('{10,   9,    1, 0, 'h0,    0, 1, 0, 0});
        vt.push_back('{0,    2048, 1, 0, 'h0,    0, 1, 0, 0});
        vt.push_back('{2047, 2047, 1, 0, 'h0050, 0, 0, 1, 1});
        vt.push_back('{2045, 2047, 2, 0, 'hF000, 2, 0, 3, 9});
        vt.push_back('{0,    0,    0, 0, 'hEFFF, 0, 0, 1, 1});

        repeat (3) @(negedge clk);
        chk("reset", "outs_in_reset", all_outs(), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", "outs_idle", all_outs(), 64'(0));

        foreach (vt[k]) begin
            v        = vt[k];
            mag_mode = v.mmode;
            cmag     = 16'(v.cmag);
            rmode    = v.rmode;
            lat      = (k == 0) ? 50 : 3;
            if (v.exp_err == 0) begin
                build_model(v.first, v.last, v.ss);
            end else begin
                exp_res.delete();
                exp_req.delete();
            end
            do_sweep(v.first, v.last, v.ss, d0);
            wait_done($sformatf("vec%0d", k), d0, 20000);
            check_sweep($sformatf("vec%0d", k), v.exp_err, d0);
            chk($sformatf("vec%0d", k), "tab_nres",
                64'(got_res.size()), 64'(v.exp_nres));
            chk($sformatf("vec%0d", k), "tab_nreq",
                64'(req_q.size()), 64'(v.exp_nreq));
        end

        // Engine busy for 5000 cycles; a second start meanwhile is ignored
        mag_mode   = 0;
        cmag       = 16'h0200;
        rmode      = 0;
        lat        = 4;
        force_busy = 1;
        build_model(12, 12, 2);
        do_sweep(12, 12, 2, d0);
        repeat (50) @(posedge clk);
        #1;
        first_channel = 12'd100;
        last_channel  = 12'd100;
        sweep_start   = 1'b1;
        @(posedge clk);
        #1;
        sweep_start = 1'b0;
        repeat (4950) @(negedge clk);
        chk("busy", "no_start_while_busy", 64'(req_q.size()), 64'(0));
        @(posedge clk);
        #1;
        force_busy = 0;
        t0 = 99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (req_q.size() != 0) begin
                t0 = i;
                break;
            end
        end
        chk("busy", "start_after_release", 64'(t0 <= 2), 64'(1));
        wait_done("busy", d0, 5000);
        check_sweep("busy", 0, d0);

        // Engine never answers
        eng_en = 0;
        exp_res.delete();
        exp_req.delete();
        exp_req.push_back({12'd4, 2'd1});
        do_sweep(4, 6, 1, d0);
        t0 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (req_q.size() != 0) begin
                t0 = cyc;
                break;
            end
        end
        wait_done("timeout", d0, 2000);
        chk("timeout", "elapsed_ok",
            64'((cyc - 4 - t0) >= TMO && (cyc - 4 - t0) <= TMO + 4), 64'(1));
        check_sweep("timeout", 1, d0);
        eng_en = 1;

        // Abort while channel 2 settles
        cmag  = 16'h0333;
        lat   = 3;
        build_model(0, 1, 1);
        do_sweep(0, 7, 1, d0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (sweep_busy && zcheck_global_channel == 12'd2) break;
        end
        @(posedge clk);
        #1;
        sweep_abort = 1'b1;
        wait_done("abort_settle", d0, 2000);
        sweep_abort = 1'b0;
        check_sweep("abort_settle", 0, d0);

        // Abort while result for channel 3 is stalled: it is still delivered
        rmode = 1;
        build_model(0, 3, 0);
        do_sweep(0, 7, 0, d0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (res_valid && res_channel == 12'd3) break;
        end
        @(posedge clk);
        #1;
        sweep_abort = 1'b1;
        wait_done("abort_emit", d0, 2000);
        sweep_abort = 1'b0;
        check_sweep("abort_emit", 0, d0);

        // Reset while a measurement is in flight
        rmode = 0;
        lat   = 100;
        do_sweep(5, 7, 2, d0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (req_q.size() != 0) break;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", "outs_zero", all_outs(), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        chk("rst_mid", "no_done", 64'(done_cnt - d0), 64'(0));
        chk("rst_mid", "idle", 64'(sweep_busy), 64'(0));

        // Randomized sweeps against the model
        mag_mode = 2;
        rmode    = 2;
        lat_rand = 1;
        spur_en  = 1;
        for (int k = 0; k < 8; k++) begin
            seed = $urandom;
            if (k % 3 == 2) begin
                f = int'($urandom_range(2043, 2047));
                l = 2047;
            end else begin
                f = int'($urandom_range(0, 2040));
                l = f + int'($urandom_range(0, 4));
            end
            t0 = int'($urandom_range(0, 3));
            build_model(f, l, t0);
            do_sweep(f, l, t0, d0);
            wait_done($sformatf("rand%0d", k), d0, 20000);
            check_sweep($sformatf("rand%0d", k), 0, d0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
